// File: rtl/bridge_rx.sv
// Receive-side parser for the UART host bridge: decodes ASCII-hex "Raaaa" / "Wdddddddd"
// request lines from the host byte stream and issues one single-cycle register-bus transaction per line.
module bridge_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic [15:0] addr_o,
    output logic [15:0] data_o,
    output logic        rw_o,
    output logic        valid_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_EOL  = 2'd3;

    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_W  = 8'h57;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    logic [1:0]  state_q,    state_d;
    logic        is_write_q, is_write_d;
    logic [1:0]  cnt_q,      cnt_d;
    logic [15:0] addr_acc_q, addr_acc_d;
    logic [15:0] data_acc_q, data_acc_d;
    logic [15:0] addr_q,     addr_d;
    logic [15:0] wdata_q,    wdata_d;
    logic        rw_q,       rw_d;
    logic        valid_q,    valid_d;

    logic        hex_ok;
    logic [3:0]  hex_nib;
    logic        is_term;

    // Letters map to 10..15: the low nibble of 'A'/'a' is 1, so adding 9 gives the digit value.
    always_comb begin
        hex_ok  = 1'b1;
        hex_nib = 4'h0;
        if (data_i >= 8'h30 && data_i <= 8'h39) begin
            hex_nib = data_i[3:0];
        end else if ((data_i >= 8'h41 && data_i <= 8'h46) ||
                     (data_i >= 8'h61 && data_i <= 8'h66)) begin
            hex_nib = data_i[3:0] + 4'd9;
        end else begin
            hex_ok = 1'b0;
        end
    end

    assign is_term = (data_i == CH_CR) || (data_i == CH_LF);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_d    = state_q;
        is_write_d = is_write_q;
        cnt_d      = cnt_q;
        addr_acc_d = addr_acc_q;
        data_acc_d = data_acc_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        valid_d    = 1'b0;

        if (valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (data_i == CH_R || data_i == CH_W) begin
                        state_d    = ST_ADDR;
                        is_write_d = (data_i == CH_W);
                        cnt_d      = 2'd0;
                        data_acc_d = 16'h0000;
                    end
                end
                ST_ADDR: begin
                    if (hex_ok) begin
                        addr_acc_d = {addr_acc_q[11:0], hex_nib};
                        cnt_d      = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            cnt_d   = 2'd0;
                            state_d = is_write_q ? ST_DATA : ST_EOL;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (hex_ok) begin
                        data_acc_d = {data_acc_q[11:0], hex_nib};
                        cnt_d      = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = ST_EOL;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EOL: begin
                    // Anything other than a terminator aborts the line silently.
                    state_d = ST_IDLE;
                    if (is_term) begin
                        valid_d = 1'b1;
                        addr_d  = addr_acc_q;
                        wdata_d = is_write_q ? data_acc_q : 16'h0000;
                        rw_d    = is_write_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            cnt_q      <= 2'd0;
            addr_acc_q <= 16'h0000;
            data_acc_q <= 16'h0000;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            rw_q       <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            cnt_q      <= cnt_d;
            addr_acc_q <= addr_acc_d;
            data_acc_q <= data_acc_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            valid_q    <= valid_d;
        end
    end

    assign addr_o  = addr_q;
    assign data_o  = wdata_q;
    assign rw_o    = rw_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_bridge_rx.sv
// Scoreboard bench for bridge_rx: a lookahead line parser predicts transactions for each byte
// stream; a negedge monitor pops and compares every valid_o pulse, including its cycle.
module tb_bridge_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        rw_o;
    logic        valid_o;

    bridge_rx dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .addr_o  (addr_o),
        .data_o  (data_o),
        .rw_o    (rw_o),
        .valid_o (valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] addr;
        logic [15:0] data;
        bit          rw;
    } txn_t;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
        bit          rw;
    } exp_t;

    logic [7:0] stream_q[$];
    txn_t       plan_q[$];
    exp_t       sb_q[$];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    // Monitor: every pulse must match the oldest expectation, on its predicted cycle.
    always @(negedge clk) begin
        exp_t e;
        if (valid_o) begin
            if (sb_q.size() == 0) begin
                check(1'b0, "unexpected_pulse",
                      $sformatf("got pulse addr=%h data=%h rw=%b at cycle %0d, required no pulse",
                                addr_o, data_o, rw_o, cyc));
            end else begin
                e = sb_q.pop_front();
                check(cyc == e.cyc && addr_o == e.addr && data_o == e.data && rw_o == e.rw, "txn",
                      $sformatf("got cyc=%0d addr=%h data=%h rw=%b, required cyc=%0d addr=%h data=%h rw=%b",
                                cyc, addr_o, data_o, rw_o, e.cyc, e.addr, e.data, e.rw));
            end
        end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            check(1'b0, "missing_pulse",
                  $sformatf("got no pulse at cycle %0d, required addr=%h data=%h rw=%b",
                            cyc, e.addr, e.data, e.rw));
        end
    end

    function automatic bit is_hex(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
               (b >= 8'h61 && b <= 8'h66);
    endfunction

    function automatic logic [3:0] hexval(input logic [7:0] b);
        logic [7:0] t;
        if (b <= 8'h39)      t = b - 8'h30;
        else if (b <= 8'h46) t = b - 8'h41 + 8'd10;
        else                 t = b - 8'h61 + 8'd10;
        return t[3:0];
    endfunction

    // Reference: scan the whole stream for lines of the form R<4 hex><term> / W<8 hex><term>.
    // A mismatching byte is consumed by the abort and scanning resumes after it.
    task automatic run_model();
        int          i;
        int          k;
        int          n;
        int          nd;
        int          sz;
        logic [31:0] v;
        logic [7:0]  b;
        txn_t        t;
        i  = 0;
        sz = stream_q.size();
        plan_q.delete();
        while (i < sz) begin
            b = stream_q[i];
            if (b == 8'h52 || b == 8'h57) begin
                nd = (b == 8'h57) ? 8 : 4;
                k  = i + 1;
                n  = 0;
                v  = '0;
                while (n < nd && k < sz && is_hex(stream_q[k])) begin
                    v = {v[27:0], hexval(stream_q[k])};
                    n++;
                    k++;
                end
                if (k >= sz) begin
                    i = sz;
                end else begin
                    if (n == nd && (stream_q[k] == 8'h0D || stream_q[k] == 8'h0A)) begin
                        t.idx  = k;
                        t.rw   = (b == 8'h57);
                        t.addr = t.rw ? v[31:16] : v[15:0];
                        t.data = t.rw ? v[15:0] : 16'h0000;
                        plan_q.push_back(t);
                    end
                    i = k + 1;
                end
            end else begin
                i++;
            end
        end
    endtask

    // '~' stands for CR and '|' for LF.
    task automatic load(input string s);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == 8'h7E)      stream_q.push_back(8'h0D);
            else if (c == 8'h7C) stream_q.push_back(8'h0A);
            else                 stream_q.push_back(c);
        end
    endtask

    // Drive the stream; idle gap cycles carry random junk on data_i that must be ignored.
    task automatic send(input int gap_min, input int gap_max);
        txn_t t;
        exp_t e;
        int   g;
        run_model();
        for (int i = 0; i < stream_q.size(); i++) begin
            @(posedge clk);
            #1;
            data_i  = stream_q[i];
            valid_i = 1'b1;
            if (plan_q.size() != 0 && plan_q[0].idx == i) begin
                t      = plan_q.pop_front();
                e.cyc  = cyc + 1;
                e.addr = t.addr;
                e.data = t.data;
                e.rw   = t.rw;
                sb_q.push_back(e);
            end
            g = $urandom_range(gap_max, gap_min);
            repeat (g) begin
                @(posedge clk);
                #1;
                valid_i = 1'b0;
                data_i  = 8'($urandom);
            end
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        stream_q.delete();
    endtask

    task automatic gen_random(input int n_msgs);
        string hexs = "0123456789ABCDEFabcdef";
        string bads = "GgxZ R.W";
        int    kind;
        int    nd;
        int    ndig;
        int    bad_pos;
        int    term;
        bit    is_w;
        for (int m = 0; m < n_msgs; m++) begin
            kind = $urandom_range(0, 5);
            is_w = ($urandom_range(0, 1) == 1);
            nd   = is_w ? 8 : 4;
            if ($urandom_range(0, 4) == 0) stream_q.push_back(8'h5A);
            stream_q.push_back(is_w ? 8'h57 : 8'h52);
            ndig    = (kind == 3) ? $urandom_range(0, nd - 1) : (kind == 4) ? nd + 1 : nd;
            bad_pos = (kind == 5) ? $urandom_range(0, nd - 1) : -1;
            for (int d = 0; d < ndig; d++) begin
                if (d == bad_pos) stream_q.push_back(bads[$urandom_range(0, 7)]);
                else              stream_q.push_back(hexs[$urandom_range(0, 21)]);
            end
            term = $urandom_range(0, 2);
            if (term != 1) stream_q.push_back(8'h0D);
            if (term != 0) stream_q.push_back(8'h0A);
        end
    endtask

    task automatic check_zero(input string name);
        check(addr_o == 16'h0000 && data_o == 16'h0000 && rw_o == 1'b0 && valid_o == 1'b0, name,
              $sformatf("got addr=%h data=%h rw=%b valid=%b, required all zero",
                        addr_o, data_o, rw_o, valid_o));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;

        load("R1234~|");
        send(0, 0);

        load("W00FFbeef~");
        send(3, 3);

        load("R12G4~R0001|");
        send(0, 1);

        load("R123~R12345~W1234567~");
        send(0, 1);

        load("W12");
        send(0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("mid_msg_reset");
        rst = 1'b0;

        load("34ABCD~RFFFF~");
        send(0, 0);

        load("R0010|W0020AAAA|R0030|");
        send(0, 0);

        gen_random(60);
        send(0, 2);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check(sb_q.size() == 0, "drain",
              $sformatf("got %0d outstanding expectations, required 0", sb_q.size()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bridge_rx.md
# bridge_rx

Receive-side parser for the UART host bridge. Consumes the byte stream from the UART receiver, decodes ASCII-hex read and write request messages from the host, and issues one single-cycle bus transaction per valid message onto the internal register bus. Sits between the UART byte receiver and the bus; read responses go back to the host through the bridge transmitter.

## Interface

No parameters.

- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- data_i  input  8  received byte from UART receiver
- valid_i  input  1  data_i valid strobe, one cycle per byte
- addr_o  output  16  bus address of decoded request
- data_o  output  16  write data (0 for reads)
- rw_o  output  1  1 = write, 0 = read
- valid_o  output  1  one-cycle transaction strobe

## Operation

- Message formats (ASCII):
  - read: 'R' (0x52), then 4 hex address digits, then terminator
  - write: 'W' (0x57), then 4 hex address digits, then 4 hex data digits, then terminator
  - terminator: CR (0x0D) or LF (0x0A); CR LF pairs are accepted because the trailing LF arrives in IDLE and is ignored
- Hex digits: '0'-'9', 'A'-'F', 'a'-'f'; most-significant nibble first; shifted into a 16-bit accumulator.
- Bytes are processed only on cycles with valid_i = 1; other cycles hold state.
- States:
  - IDLE: 'R' -> ADDR, is_write=0, nibble count=0; 'W' -> ADDR, is_write=1; any other byte ignored, stay IDLE.
  - ADDR: hex digit -> shift into address, count+1; on 4th digit -> DATA if is_write, else EOL; any non-hex byte -> IDLE (abort).
  - DATA: hex digit -> shift into data, count+1; on 4th digit -> EOL; non-hex -> IDLE (abort).
  - EOL: CR or LF -> issue transaction, -> IDLE; any other byte (including hex digit) -> IDLE (abort).
- Abort discards the partial message silently; no transaction, no error output. An 'R'/'W' that causes an abort does not start a new message; the host must resend.
- Transaction: addr_o = accumulated address; data_o = accumulated data (write) or 0x0000 (read); rw_o = is_write; valid_o = 1 for exactly one cycle.
- addr_o, data_o, rw_o hold their last issued values until the next transaction; they are meaningful only while valid_o = 1.

## Timing

- Reset values: addr_o=0, data_o=0, rw_o=0, valid_o=0, state=IDLE, counters and accumulators cleared.
- rst has priority over valid_i; reset mid-message discards it, and the next byte is interpreted from IDLE.
- Latency: valid_o asserts the cycle after the clock edge that samples the terminator with valid_i=1; all outputs are registered.
- Minimum message spacing is one byte; bytes may arrive on consecutive cycles (valid_i held high) and each is consumed, so back-to-back messages yield back-to-back transactions.
- No backpressure: downstream must accept the valid_o pulse; no output ready exists.
- The nibble counter is 2 bits; it resets to 0 on entering ADDR and on ADDR->DATA, and never wraps mid-field.

## Test plan

- After reset, send "R1234\r\n" on consecutive cycles -> exactly one valid_o pulse, one cycle after '\r', with addr_o=0x1234, rw_o=0, data_o=0x0000; the trailing '\n' produces nothing.
- Send "W00FFbeef\r" with 3 idle cycles between bytes -> one pulse: addr_o=0x00FF, data_o=0xBEEF, rw_o=1.
- Send "R12G4\r", then "R0001\n" -> no pulse for the first message; one pulse for the second with addr_o=0x0001, rw_o=0.
- Short/long: "R123\r" and "R12345\r" -> no pulses; "W1234567\r" (7 digits) -> no pulse.
- Assert rst for 1 cycle after "W12", then send "34ABCD\r" and "RFFFF\r" -> no pulse from the fragment; one read pulse addr_o=0xFFFF; all outputs are 0 in the cycle after rst.
- Stream "R0010\nW0020AAAA\nR0030\n" continuously -> three pulses in order: (0x0010,rd), (0x0020,0xAAAA,wr), (0x0030,rd).
